// File: rtl/bsg_two_fifo_ctrl_width_p36_pkg.sv
// Shared definitions for the two-element FIFO controller.
//   occ_e                 : occupancy encoding (EMPTY/ONE/FULL), matches count_o.
//   BSG_PROTOCOL_ASSERT   : simulation-only handshake check used by bsg FIFOs;
//                           reports a protocol violation without touching state.

`ifndef BSG_PROTOCOL_ASSERT
`ifndef SYNTHESIS
`define BSG_PROTOCOL_ASSERT(clk, rst_n, cond, msg) \
  always_ff @(posedge clk) \
    if (rst_n) assert (cond) else $warning(msg);
`else
`define BSG_PROTOCOL_ASSERT(clk, rst_n, cond, msg)
`endif
`endif

package bsg_two_fifo_ctrl_width_p36_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Next occupancy from the qualified handshake events.
  function automatic occ_e occ_next(input occ_e cur, input logic enq, input logic deq);
    occ_e nxt;
    nxt = cur;
    unique case (cur)
      OCC_EMPTY: if (enq) nxt = OCC_ONE;
      OCC_ONE: begin
        if (enq && !deq)      nxt = OCC_FULL;
        else if (deq && !enq) nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (deq) nxt = OCC_ONE;
      default:   nxt = OCC_EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w_synth_width_p36_els_p2_read_write_same_addr_p0_harden_p0.sv
// Two-entry, 36-bit storage with one synchronous write port and one
// combinational read port. Reading and writing the same address in the same
// cycle is not allowed.
//   w_clk_i, w_reset_i          : write clock, active-high reset (gates writes)
//   w_v_i, w_addr_i, w_data_i   : write enable, address, payload
//   r_v_i, r_addr_i             : read valid, address
//   r_data_o                    : combinational read data

module bsg_mem_1r1w_synth_width_p36_els_p2_read_write_same_addr_p0_harden_p0 #(
  parameter int width_p = 36,
  parameter int els_p   = 2
) (
  input  logic               w_clk_i,
  input  logic               w_reset_i,
  input  logic               w_v_i,
  input  logic               w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic               r_v_i,
  input  logic               r_addr_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // NOTE: the storage array has no reset; its contents are only meaningful
  // once written, and a reset on every bit would cost a reset tree for nothing.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i && !w_reset_i) mem_r[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_r[r_addr_i];

`ifndef SYNTHESIS
  always_ff @(posedge w_clk_i) begin
    if (!w_reset_i)
      assert (!(w_v_i && r_v_i && (w_addr_i == r_addr_i)))
        else $error("bsg_mem_1r1w: read and write to same address");
  end
`endif

endmodule

// File: rtl/bsg_two_fifo_ctrl_width_p36.sv
// Two-element FIFO: ready-then-valid input, valid-yumi output. Owns the
// head/tail pointers and occupancy, and drives the 2x36 storage macro.
//   clk_i, reset_n_i   : clock, asynchronous active-low reset
//   v_i, data_i        : producer valid/payload (legal only while ready_o=1)
//   ready_o            : FIFO can accept (registered)
//   v_o, data_o        : head valid (registered) / head payload
//   yumi_i             : consumer takes head (legal only while v_o=1)
//   count_o            : occupancy 0..2 (registered)

module bsg_two_fifo_ctrl_width_p36
  import bsg_two_fifo_ctrl_width_p36_pkg::*;
#(
  parameter int width_p = 36,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic [1:0]         count_o
);

  if (els_p != 2) begin : g_els_check
    $error("bsg_two_fifo_ctrl: els_p must be 2");
  end

  occ_e count_r, count_next;
  logic wptr_r, rptr_r;
  logic enq, deq;

  // Illegal handshakes are masked here so they can never corrupt state.
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count_r;
    count_next = occ_next(count_r, enq, deq);
  end

  // NOTE: reset is asynchronous so outputs drop immediately, without waiting
  // for a clock; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= OCC_EMPTY;
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      ready_o <= 1'b0;
      v_o     <= 1'b0;
    end else begin
      count_r <= count_next;
      wptr_r  <= wptr_r ^ enq;
      rptr_r  <= rptr_r ^ deq;
      // Flags decoded from next state so they are registered, not combinational.
      ready_o <= (count_next != OCC_FULL);
      v_o     <= (count_next != OCC_EMPTY);
    end
  end

  assign count_o = count_r;

  // No enqueue while full keeps wptr_r != rptr_r whenever a read is valid
  // alongside a write; in EMPTY the read is don't-care since v_o=0.
  bsg_mem_1r1w_synth_width_p36_els_p2_read_write_same_addr_p0_harden_p0 #(
    .width_p(width_p),
    .els_p  (els_p)
  ) u_mem (
    .w_clk_i  (clk_i),
    .w_reset_i(~reset_n_i),
    .w_v_i    (enq),
    .w_addr_i (wptr_r),
    .w_data_i (data_i),
    .r_v_i    (v_o),
    .r_addr_i (rptr_r),
    .r_data_o (data_o)
  );

  `BSG_PROTOCOL_ASSERT(clk_i, reset_n_i, !(yumi_i && !v_o), "protocol violation: yumi_i while v_o=0")
  `BSG_PROTOCOL_ASSERT(clk_i, reset_n_i, !(v_i && !ready_o), "protocol violation: v_i while ready_o=0")

endmodule
